// File: rtl/spi_pkg.sv
// Shared SPI definitions: command encodings, frame/data widths and FSM states.
// Used by both the master and the slave side of the link.
package spi_pkg;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Counter reload values; the counter ends a phase when it reaches zero.
  localparam logic [3:0] SHIFT_LOAD = 4'(FRAME_W - 1);
  localparam logic [3:0] RECV_LOAD  = 4'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_CMD   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_WAIT  = 3'd4,
    ST_RECV  = 3'd5,
    ST_GAP   = 3'd6
  } spi_state_e;

  function automatic logic is_read_data(input logic [1:0] cmd);
    return cmd == CMD_RD_DATA;
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load, MSB-first shift register. o_next is the value after one shift,
// so a caller can capture the completed word in the same cycle as the last bit.
module spi_shift_reg #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_data,
  input  logic         i_shift,
  input  logic         i_ser_in,
  output logic         o_msb,
  output logic [W-1:0] o_next
);

  logic [W-1:0] r_data;

  assign o_msb  = r_data[W-1];
  assign o_next = {r_data[W-2:0], i_ser_in};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_load_data;
    end else if (i_shift) begin
      r_data <= o_next;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master: sends a 10-bit {cmd,din} frame MSB first and, for read-data frames,
// receives one byte on MISO after RD_WAIT idle cycles.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned RD_WAIT = 2,
  parameter int unsigned GAP     = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [1:0]        i_cmd,
  input  logic [DATA_W-1:0] i_din,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_ss_n,
  output logic              o_mosi,
  input  logic              i_miso,
  output logic [2:0]        o_dbg_state
);

  localparam logic [3:0] WAIT_LOAD = 4'(RD_WAIT - 1);
  localparam logic [3:0] GAP_LOAD  = 4'(GAP - 1);

  spi_state_e          r_state;
  spi_state_e          w_next_state;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_load;
  logic                w_cnt_zero;
  logic [1:0]          r_cmd;
  logic [DATA_W-1:0]   r_rd_data;
  logic                w_accept;
  logic                w_tx_msb;
  logic [FRAME_W-1:0]  w_tx_next_unused;
  logic                w_rx_msb_unused;
  logic [DATA_W-1:0]   w_rx_next;

  assign w_cnt_zero  = (r_cnt == 4'd0);
  assign w_accept    = (r_state == ST_IDLE) && i_start;
  assign o_dbg_state = r_state;
  assign o_rd_data   = r_rd_data;

  spi_shift_reg #(.W(FRAME_W)) u_tx (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (w_accept),
    .i_load_data ({i_cmd, i_din}),
    .i_shift     (r_state == ST_SHIFT),
    .i_ser_in    (1'b0),
    .o_msb       (w_tx_msb),
    .o_next      (w_tx_next_unused)
  );

  spi_shift_reg #(.W(DATA_W)) u_rx (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (1'b0),
    .i_load_data ('0),
    .i_shift     (r_state == ST_RECV),
    .i_ser_in    (i_miso),
    .o_msb       (w_rx_msb_unused),
    .o_next      (w_rx_next)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_next_state = ST_SEL;
      ST_SEL:   w_next_state = ST_CMD;
      ST_CMD:   w_next_state = ST_SHIFT;
      ST_SHIFT: if (w_cnt_zero) w_next_state = is_read_data(r_cmd) ? ST_WAIT : ST_GAP;
      ST_WAIT:  if (w_cnt_zero) w_next_state = ST_RECV;
      ST_RECV:  if (w_cnt_zero) w_next_state = ST_GAP;
      ST_GAP:   if (w_cnt_zero) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Single phase counter: reloaded whenever a new state is entered.
  always_comb begin
    w_cnt_load = 4'd0;
    case (w_next_state)
      ST_SHIFT: w_cnt_load = SHIFT_LOAD;
      ST_WAIT:  w_cnt_load = WAIT_LOAD;
      ST_RECV:  w_cnt_load = RECV_LOAD;
      ST_GAP:   w_cnt_load = GAP_LOAD;
      default:  w_cnt_load = 4'd0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= 4'd0;
    end else if (w_next_state != r_state) begin
      r_cnt <= w_cnt_load;
    end else if (!w_cnt_zero) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cmd     <= 2'b00;
      r_rd_data <= '0;
    end else begin
      if (w_accept) begin
        r_cmd <= i_cmd;
      end
      if ((r_state == ST_RECV) && w_cnt_zero) begin
        r_rd_data <= w_rx_next;
      end
    end
  end

  always_comb begin
    o_ss_n     = 1'b1;
    o_mosi     = 1'b0;
    o_busy     = (r_state != ST_IDLE);
    o_done     = 1'b0;
    o_rd_valid = 1'b0;
    case (r_state)
      ST_SEL, ST_WAIT, ST_RECV: o_ss_n = 1'b0;
      ST_CMD, ST_SHIFT: begin
        o_ss_n = 1'b0;
        o_mosi = w_tx_msb;
      end
      ST_GAP: begin
        o_done     = (r_cnt == GAP_LOAD);
        o_rd_valid = (r_cnt == GAP_LOAD) && is_read_data(r_cmd);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a behavioural slave with a 256-byte RAM on the SPI pins,
// table-driven directed frames, random frames against a reference model, and corner sequences.
module tb_spi_master;
  import spi_pkg::*;

  localparam int RD_WAIT = 2;
  localparam int GAP     = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [7:0] din = 8'h00;
  logic       miso = 1'b0;
  logic       busy, done, rd_valid, ss_n, mosi;
  logic [7:0] rd_data;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  spi_master #(.RD_WAIT(RD_WAIT), .GAP(GAP)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_cmd(cmd), .i_din(din),
    .o_busy(busy), .o_done(done), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
    .o_ss_n(ss_n), .o_mosi(mosi), .i_miso(miso), .o_dbg_state(dbg_state)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // Scoreboard of frames expected on the wire, in issue order.
  logic [9:0] exp_q[$];

  // Slave model state and monitor results.
  logic [7:0]  s_ram[256];
  logic [7:0]  s_addr = 8'h00;
  int          low_cnt = 0, high_cnt = 0, last_high = 0;
  logic [11:0] mosi_word = '0;
  int          frame_cnt = 0, done_cnt = 0, rv_cnt = 0, last_len = 0;
  logic [11:0] last_mosi = '0;
  logic        last_end_done = 1'b0;
  logic [7:0]  last_end_rd = 8'h00;

  // Reference model: plain address register plus memory array.
  logic [7:0] ref_ram[256];
  logic [7:0] ref_addr = 8'h00;

  always @(negedge clk) begin
    if (ss_n === 1'b0) begin
      if (low_cnt == 0) last_high = high_cnt;
      if (low_cnt < 12) mosi_word = {mosi_word[10:0], mosi};
      miso = 1'b0;
      if (low_cnt >= 12 + RD_WAIT && low_cnt < 20 + RD_WAIT && mosi_word[9:8] == CMD_RD_DATA) begin
        int j;
        j = low_cnt - 12 - RD_WAIT;
        miso = s_ram[s_addr][7 - j];
      end
      low_cnt++;
    end else begin
      if (low_cnt > 0) begin
        frame_cnt++;
        last_len      = low_cnt;
        last_mosi     = mosi_word;
        last_end_done = done;
        last_end_rd   = rd_data;
        if (low_cnt >= 12) begin
          if (exp_q.size() == 0) check("sb_unexpected_frame", {22'd0, mosi_word[9:0]}, 32'hFFFF_FFFF);
          else check("sb_frame", {22'd0, mosi_word[9:0]}, {22'd0, exp_q.pop_front()});
          case (mosi_word[9:8])
            CMD_WR_ADDR, CMD_RD_ADDR: s_addr = mosi_word[7:0];
            CMD_WR_DATA: s_ram[s_addr] = mosi_word[7:0];
            default: ;
          endcase
        end
        high_cnt = 0;
      end
      low_cnt   = 0;
      mosi_word = '0;
      miso      = 1'b0;
      high_cnt++;
    end
    if (done === 1'b1) done_cnt++;
    if (rd_valid === 1'b1) rv_cnt++;
  end

  task automatic ref_update(input logic [1:0] c, input logic [7:0] d);
    case (c)
      CMD_WR_ADDR, CMD_RD_ADDR: ref_addr = d;
      CMD_WR_DATA: ref_ram[ref_addr] = d;
      default: ;
    endcase
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with busy low.
  task automatic run_frame(input logic [1:0] c, input logic [7:0] d, input int exp_len, input logic [7:0] exp_rd);
    int d0, r0, f0;
    bit ok;
    d0 = done_cnt; r0 = rv_cnt; f0 = frame_cnt;
    exp_q.push_back({c, d});
    start = 1'b1; cmd = c; din = d;
    @(negedge clk);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      start = 1'($urandom_range(0, 1));
      cmd = 2'($urandom);
      din = 8'($urandom);
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check("frame_timeout", {31'd0, ok}, 32'd1);
    check("frame_count", frame_cnt - f0, 32'd1);
    check("ss_low_len", last_len, exp_len);
    check("mosi_bits", {20'd0, last_mosi}, {20'd0, 1'b0, c[1], c, d});
    check("done_at_ss_rise", {31'd0, last_end_done}, 32'd1);
    check("done_once", done_cnt - d0, 32'd1);
    check("rd_valid_count", rv_cnt - r0, (c == CMD_RD_DATA) ? 32'd1 : 32'd0);
    if (c == CMD_RD_DATA) check("rd_data", {24'd0, last_end_rd}, {24'd0, exp_rd});
    ref_update(c, d);
  endtask

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] din;
    int         exp_len;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int d0, f0;
    bit ok;
    logic [1:0] c;
    logic [7:0] d;

    for (int i = 0; i < 256; i++) begin
      d = 8'($urandom_range(1, 255));
      s_ram[i] = d;
      ref_ram[i] = d;
    end

    vecs[0] = '{CMD_WR_ADDR, 8'hFF, 12, 8'h00};
    vecs[1] = '{CMD_WR_DATA, 8'hFF, 12, 8'h00};
    vecs[2] = '{CMD_RD_ADDR, 8'hFF, 12, 8'h00};
    vecs[3] = '{CMD_RD_DATA, 8'h00, 22, 8'hFF};
    vecs[4] = '{CMD_WR_ADDR, 8'h00, 12, 8'h00};
    vecs[5] = '{CMD_WR_DATA, 8'h00, 12, 8'h00};
    vecs[6] = '{CMD_RD_ADDR, 8'h00, 12, 8'h00};
    vecs[7] = '{CMD_RD_DATA, 8'h5A, 22, 8'h00};

    // Reset state.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ss_n", {31'd0, ss_n}, 32'd1);
    check("rst_mosi", {31'd0, mosi}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_rd_data", {24'd0, rd_data}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    @(negedge clk);

    // Directed frames with 8'hFF, then 8'h00 over a nonzero preloaded memory.
    foreach (vecs[i]) run_frame(vecs[i].cmd, vecs[i].din, vecs[i].exp_len, vecs[i].exp_rd);
    check("slave_ram_255", {24'd0, s_ram[255]}, 32'hFF);
    check("slave_ram_0", {24'd0, s_ram[0]}, 32'h00);

    // Reset at SHIFT bit 5 while a stray start is held high.
    d0 = done_cnt; f0 = frame_cnt;
    start = 1'b1; cmd = CMD_WR_DATA; din = 8'($urandom);
    @(negedge clk);
    repeat (7) @(negedge clk);
    check("abort_in_shift", {29'd0, dbg_state}, {29'd0, ST_SHIFT});
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ss_n", {31'd0, ss_n}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rd_data", {24'd0, rd_data}, 32'd0);
    repeat (5) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 32'd0);
    check("abort_len", last_len, 32'd8);
    check("abort_frames", frame_cnt - f0, 32'd1);
    run_frame(CMD_RD_DATA, 8'h00, 20 + RD_WAIT, ref_ram[ref_addr]);

    // Back-to-back: start held high across two identical frames.
    d = 8'($urandom);
    d0 = done_cnt; f0 = frame_cnt;
    exp_q.push_back({CMD_WR_ADDR, d});
    exp_q.push_back({CMD_WR_ADDR, d});
    start = 1'b1; cmd = CMD_WR_ADDR; din = d;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_cnt - f0 >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    for (int i = 0; i < 20 && busy !== 1'b0; i++) @(negedge clk);
    check("b2b_timeout", {31'd0, ok}, 32'd1);
    check("b2b_ss_high_gap", last_high, GAP + 1);
    check("b2b_done_count", done_cnt - d0, 32'd2);
    ref_update(CMD_WR_ADDR, d);
    @(negedge clk);

    // Random frames against the reference model.
    for (int n = 0; n < 30; n++) begin
      c = 2'($urandom_range(0, 3));
      d = (c == CMD_RD_ADDR || c == CMD_WR_ADDR) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      run_frame(c, d, (c == CMD_RD_DATA) ? 20 + RD_WAIT : 12, ref_ram[ref_addr]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    check("sb_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
